cond_exec_controller: RTL and testbench

Sequencing controller for conditional execution in the EXE stage of the ARM pipeline. It owns the NZCV status register and evaluates each EXE instruction's 4-bit condition field against it. It decides whether the instruction commits or is annulled, updates the flags for committed S-instructions, and generates the branch-taken/flush sequence with a wrong-path shadow window. It also keeps commit/annul event counters for debug.

---
 rtl/cond_exec_controller.sv | 141 ++++++++++++++
 tb/tb_cond_exec_controller.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/cond_exec_controller.sv
// Conditional-execution controller for the EXE stage: owns NZCV, decides
// commit/annul per instruction, drives branch-taken and the wrong-path
// shadow window, and keeps commit/annul debug counters.
module cond_exec_controller #(
  parameter int unsigned SHADOW = 1,
  parameter int unsigned CNT_W  = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             exeValid,
  input  logic [3:0]       exeCond,
  input  logic             exeSetFlags,
  input  logic             exeIsBranch,
  input  logic [3:0]       aluFlags,
  input  logic             cntClr,
  output logic [3:0]       statusReg,
  output logic             exeCommit,
  output logic             branchTaken,
  output logic             inShadow,
  output logic [CNT_W-1:0] execCount,
  output logic [CNT_W-1:0] annulCount
);

  localparam int unsigned SCNT_W = 3;

  typedef enum logic {
    ST_RUN    = 1'b0,
    ST_SHADOW = 1'b1
  } state_t;

  state_t              r_state;
  state_t              w_next_state;
  logic [SCNT_W-1:0]   r_shadow_cnt;
  logic [SCNT_W-1:0]   w_next_shadow_cnt;
  logic [3:0]          r_status;
  logic [CNT_W-1:0]    r_exec_cnt;
  logic [CNT_W-1:0]    r_annul_cnt;
  logic                w_base;
  logic                w_pass;
  logic                w_commit;
  logic                w_branch;
  logic                w_n, w_z, w_c, w_v;

  assign w_n = r_status[3];
  assign w_z = r_status[2];
  assign w_c = r_status[1];
  assign w_v = r_status[0];

  // Condition evaluation: even codes test the base predicate, odd codes its inverse (1111 always passes)
  always_comb begin
    w_base = 1'b1;
    case (exeCond[3:1])
      3'b000:  w_base = w_z;
      3'b001:  w_base = w_c;
      3'b010:  w_base = w_n;
      3'b011:  w_base = w_v;
      3'b100:  w_base = w_c & ~w_z;
      3'b101:  w_base = (w_n == w_v);
      3'b110:  w_base = ~w_z & (w_n == w_v);
      default: w_base = 1'b1;
    endcase
    w_pass = w_base ^ (exeCond[0] & (exeCond[3:1] != 3'b111));
  end

  // State register with shadow down-counter
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state      <= ST_RUN;
      r_shadow_cnt <= '0;
    end else begin
      r_state      <= w_next_state;
      r_shadow_cnt <= w_next_shadow_cnt;
    end
  end

  // Next-state: enter SHADOW on a taken branch, leave when the counter expires
  always_comb begin
    w_next_state      = r_state;
    w_next_shadow_cnt = r_shadow_cnt;
    case (r_state)
      ST_RUN: begin
        if (w_branch) begin
          w_next_state      = ST_SHADOW;
          w_next_shadow_cnt = SCNT_W'(SHADOW);
        end
      end
      ST_SHADOW: begin
        w_next_shadow_cnt = r_shadow_cnt - SCNT_W'(1);
        if (r_shadow_cnt <= SCNT_W'(1)) begin
          w_next_state = ST_RUN;
        end
      end
      default: begin
        w_next_state      = ST_RUN;
        w_next_shadow_cnt = '0;
      end
    endcase
  end

  // Outputs: commit/branch only in RUN and never while reset is asserted
  always_comb begin
    w_commit = 1'b0;
    w_branch = 1'b0;
    if (rst && (r_state == ST_RUN)) begin
      w_commit = exeValid & w_pass;
      w_branch = exeValid & w_pass & exeIsBranch;
    end
  end

  // NZCV register: only committed S-instructions write it
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_status <= 4'b0000;
    end else if (w_commit && exeSetFlags) begin
      r_status <= aluFlags;
    end
  end

  // Debug event counters; clear wins over increment
  always_ff @(posedge clk) begin
    if (!rst || cntClr) begin
      r_exec_cnt  <= '0;
      r_annul_cnt <= '0;
    end else begin
      if (w_commit) begin
        r_exec_cnt <= r_exec_cnt + CNT_W'(1);
      end
      if (exeValid && !w_commit) begin
        r_annul_cnt <= r_annul_cnt + CNT_W'(1);
      end
    end
  end

  assign statusReg   = r_status;
  assign exeCommit   = w_commit;
  assign branchTaken = w_branch;
  assign inShadow    = (r_state == ST_SHADOW);
  assign execCount   = r_exec_cnt;
  assign annulCount  = r_annul_cnt;

endmodule

// File: tb/tb_cond_exec_controller.sv
// Directed bench for cond_exec_controller (SHADOW=2, CNT_W=4).
module tb_cond_exec_controller;

  logic       clk = 1'b0;
  logic       rst;
  logic       exeValid;
  logic [3:0] exeCond;
  logic       exeSetFlags;
  logic       exeIsBranch;
  logic [3:0] aluFlags;
  logic       cntClr;
  logic [3:0] statusReg;
  logic       exeCommit;
  logic       branchTaken;
  logic       inShadow;
  logic [3:0] execCount;
  logic [3:0] annulCount;

  int checks = 0;
  int errors = 0;

  cond_exec_controller #(.SHADOW(2), .CNT_W(4)) dut (
    .clk(clk), .rst(rst), .exeValid(exeValid), .exeCond(exeCond),
    .exeSetFlags(exeSetFlags), .exeIsBranch(exeIsBranch), .aluFlags(aluFlags),
    .cntClr(cntClr), .statusReg(statusReg), .exeCommit(exeCommit),
    .branchTaken(branchTaken), .inShadow(inShadow), .execCount(execCount),
    .annulCount(annulCount)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive one EXE slot, then let combinational outputs settle
  task automatic drv(input logic v, input logic [3:0] c, input logic s,
                     input logic b, input logic [3:0] f);
    exeValid    = v;
    exeCond     = c;
    exeSetFlags = s;
    exeIsBranch = b;
    aluFlags    = f;
    #1;
  endtask

  // Reference condition table, written out per code
  function automatic logic ref_pass(input logic [3:0] nzcv, input logic [3:0] c);
    logic n, z, cf, v;
    {n, z, cf, v} = nzcv;
    case (c)
      4'h0: return z;
      4'h1: return !z;
      4'h2: return cf;
      4'h3: return !cf;
      4'h4: return n;
      4'h5: return !n;
      4'h6: return v;
      4'h7: return !v;
      4'h8: return cf && !z;
      4'h9: return !cf || z;
      4'hA: return n == v;
      4'hB: return n != v;
      4'hC: return !z && (n == v);
      4'hD: return z || (n != v);
      default: return 1'b1;
    endcase
  endfunction

  initial begin
    rst = 1'b0;
    cntClr = 1'b0;
    drv(1'b0, 4'h0, 1'b0, 1'b0, 4'h0);

    // Reset held for two edges; commit/branch forced low meanwhile
    tick();
    drv(1'b1, 4'hE, 1'b1, 1'b1, 4'hF);
    chk("rst_commit", 16'(exeCommit), 16'd0);
    chk("rst_branch", 16'(branchTaken), 16'd0);
    tick();
    chk("rst_status", 16'(statusReg), 16'h0);
    chk("rst_exec", 16'(execCount), 16'd0);
    chk("rst_annul", 16'(annulCount), 16'd0);
    chk("rst_shadow", 16'(inShadow), 16'd0);
    drv(1'b0, 4'h0, 1'b0, 1'b0, 4'h0);
    rst = 1'b1;

    // AL with S=1 writes flags on the next edge
    drv(1'b1, 4'hE, 1'b1, 1'b0, 4'h4);
    chk("al_commit", 16'(exeCommit), 16'd1);
    tick();
    chk("al_status", 16'(statusReg), 16'h4);
    chk("al_exec", 16'(execCount), 16'd1);

    // Back-to-back: clear flags, CMP sets Z, EQ commits next cycle
    drv(1'b1, 4'hE, 1'b1, 1'b0, 4'h0);
    tick();
    chk("clr_status", 16'(statusReg), 16'h0);
    drv(1'b1, 4'hE, 1'b1, 1'b0, 4'h4);
    tick();
    drv(1'b1, 4'h0, 1'b0, 1'b0, 4'h0);
    chk("b2b_eq_commit", 16'(exeCommit), 16'd1);
    tick();
    chk("b2b_exec", 16'(execCount), 16'd4);
    drv(1'b1, 4'hE, 1'b1, 1'b0, 4'h4);
    tick();
    drv(1'b1, 4'h1, 1'b1, 1'b0, 4'hF);
    chk("b2b_ne_commit", 16'(exeCommit), 16'd0);
    tick();
    chk("b2b_ne_annul", 16'(annulCount), 16'd1);
    chk("b2b_ne_status", 16'(statusReg), 16'h4);
    chk("b2b_ne_exec", 16'(execCount), 16'd5);

    // Taken branch with SHADOW=2: two annulled cycles then RUN
    drv(1'b1, 4'hE, 1'b0, 1'b1, 4'h0);
    chk("br_taken", 16'(branchTaken), 16'd1);
    chk("br_commit", 16'(exeCommit), 16'd1);
    chk("br_shadow_t", 16'(inShadow), 16'd0);
    tick();
    chk("sh1_in", 16'(inShadow), 16'd1);
    drv(1'b1, 4'hE, 1'b1, 1'b1, 4'hF);
    chk("sh1_commit", 16'(exeCommit), 16'd0);
    chk("sh1_branch", 16'(branchTaken), 16'd0);
    tick();
    chk("sh2_in", 16'(inShadow), 16'd1);
    chk("sh2_commit", 16'(exeCommit), 16'd0);
    tick();
    chk("sh_exit", 16'(inShadow), 16'd0);
    chk("sh_status", 16'(statusReg), 16'h4);
    chk("sh_annul", 16'(annulCount), 16'd3);
    drv(1'b1, 4'hE, 1'b0, 1'b0, 4'h0);
    chk("after_sh_commit", 16'(exeCommit), 16'd1);
    tick();
    chk("after_sh_exec", 16'(execCount), 16'd7);

    // Branch with S=1: flags and shadow on same edge; bubbles burn the shadow
    drv(1'b1, 4'hE, 1'b1, 1'b1, 4'h2);
    chk("brs_taken", 16'(branchTaken), 16'd1);
    tick();
    chk("brs_status", 16'(statusReg), 16'h2);
    chk("brs_in", 16'(inShadow), 16'd1);
    drv(1'b0, 4'hE, 1'b1, 1'b0, 4'hF);
    chk("bub_commit", 16'(exeCommit), 16'd0);
    tick();
    tick();
    chk("bub_exit", 16'(inShadow), 16'd0);
    chk("bub_annul", 16'(annulCount), 16'd3);
    chk("bub_exec", 16'(execCount), 16'd8);
    chk("bub_status", 16'(statusReg), 16'h2);

    // Failed branch: EQ with Z=0
    drv(1'b1, 4'h0, 1'b0, 1'b1, 4'h0);
    chk("fbr_taken", 16'(branchTaken), 16'd0);
    chk("fbr_commit", 16'(exeCommit), 16'd0);
    tick();
    chk("fbr_shadow", 16'(inShadow), 16'd0);
    chk("fbr_annul", 16'(annulCount), 16'd4);

    // Spot examples from the condition table
    drv(1'b1, 4'hE, 1'b1, 1'b0, 4'h9);
    tick();
    drv(1'b1, 4'hC, 1'b0, 1'b0, 4'h0);
    chk("ex_1001_gt", 16'(exeCommit), 16'd1);
    drv(1'b1, 4'hE, 1'b1, 1'b0, 4'h4);
    tick();
    drv(1'b1, 4'hD, 1'b0, 1'b0, 4'h0);
    chk("ex_0100_le", 16'(exeCommit), 16'd1);
    drv(1'b1, 4'hE, 1'b1, 1'b0, 4'h2);
    tick();
    drv(1'b1, 4'h8, 1'b0, 1'b0, 4'h0);
    chk("ex_0010_hi", 16'(exeCommit), 16'd1);

    // Full sweep: every flag value against every condition
    for (int f = 0; f < 16; f++) begin
      drv(1'b1, 4'hE, 1'b1, 1'b0, 4'(f));
      tick();
      for (int c = 0; c < 16; c++) begin
        drv(1'b1, 4'(c), 1'b0, 1'b0, 4'h0);
        chk($sformatf("sweep_f%0h_c%0h", f, c), 16'(exeCommit), 16'(ref_pass(4'(f), 4'(c))));
      end
    end
    drv(1'b0, 4'h0, 1'b0, 1'b0, 4'h0);

    // Clear wins over a simultaneous commit
    cntClr = 1'b1;
    drv(1'b1, 4'hE, 1'b0, 1'b0, 4'h0);
    tick();
    cntClr = 1'b0;
    chk("clr_exec", 16'(execCount), 16'd0);
    chk("clr_annul", 16'(annulCount), 16'd0);

    // 16 commits wrap a 4-bit counter
    for (int i = 0; i < 15; i++) tick();
    chk("wrap_15", 16'(execCount), 16'hF);
    tick();
    chk("wrap_0", 16'(execCount), 16'd0);
    chk("wrap_annul", 16'(annulCount), 16'd0);

    // Reset in the middle of a shadow window
    drv(1'b1, 4'hE, 1'b0, 1'b1, 4'h0);
    tick();
    chk("rs_in", 16'(inShadow), 16'd1);
    rst = 1'b0;
    drv(1'b1, 4'hE, 1'b0, 1'b0, 4'h0);
    tick();
    chk("rs_shadow", 16'(inShadow), 16'd0);
    chk("rs_exec", 16'(execCount), 16'd0);
    chk("rs_status", 16'(statusReg), 16'h0);
    rst = 1'b1;
    #1;
    chk("rs_run_commit", 16'(exeCommit), 16'd1);
    tick();
    chk("rs_run_exec", 16'(execCount), 16'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
